// File: rtl/hub75_pkg.sv
// Shared types, phase lengths and helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StPost,
    StLatch,
    StDisplay,
    StBlank
  } state_e;

  localparam int unsigned PRE_LEN   = 1;
  localparam int unsigned POST_LEN  = 1;
  localparam int unsigned LATCH_LEN = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((longint'(1) << r) < longint'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM display timer: latches the plane on-time (and dim threshold with SCAN_BRIGHTNESS_EN)
// in LATCH, then flags the end of DISPLAY and the OE-on window from the shared counter.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PLANE_W = 1,
  parameter int unsigned BASE_ON = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [PLANE_W-1:0] i_plane,
  input  logic [CNT_W-1:0]   i_cnt,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [7:0]         i_brightness,
`endif
  output logic               o_done,
  output logic               o_oe_on
);

  logic [CNT_W-1:0] w_on_time;
  logic [CNT_W-1:0] r_on_time;

  assign w_on_time = CNT_W'(BASE_ON) << i_plane;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_on_time <= '0;
    end else if (i_load) begin
      r_on_time <= w_on_time;
    end
  end

  assign o_done = (i_cnt == r_on_time - 1'b1);

`ifdef SCAN_BRIGHTNESS_EN
  localparam int unsigned PROD_W = CNT_W + 8;

  logic [PROD_W-1:0] w_prod;
  logic [CNT_W-1:0]  r_thresh;

  assign w_prod = PROD_W'(w_on_time) * PROD_W'(i_brightness);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_thresh <= '0;
    end else if (i_load) begin
      r_thresh <= w_prod[PROD_W-1:8];
    end
  end

  // Dimming shortens the lit window only; DISPLAY length is still r_on_time.
  assign o_oe_on = (i_cnt < r_thresh);
`else
  assign o_oe_on = 1'b1;
`endif

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/plane scan sequencer with BCM bit planes; optional global dimming via the
// SCAN_BRIGHTNESS_EN macro (adds the i_brightness port).
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned COLS     = 32,
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned PLANES   = 4,
  parameter int unsigned BASE_ON  = 64,
  parameter int unsigned DEAD     = 250,
  localparam int unsigned PLANE_W = (PLANES > 1) ? clog2(PLANES) : 1,
  localparam int unsigned COL_W   = (COLS > 1) ? clog2(COLS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [7:0]          i_brightness,
`endif
  output logic                o_ce,
  output logic                o_clk_en,
  output logic                o_lat,
  output logic                o_oe,
  output logic                o_busy,
  output logic [ROW_BITS-1:0] o_row_addr,
  output logic [PLANE_W-1:0]  o_plane,
  output logic [COL_W-1:0]    o_col_addr,
  output logic                o_frame_start
);

  localparam int unsigned MAX_ON = BASE_ON << (PLANES - 1);
  localparam int unsigned CNT_W  = clog2(max3(COLS, DEAD, MAX_ON)) + 1;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ROW_BITS-1:0] r_row, w_row_nxt;
  logic [PLANE_W-1:0]  r_plane, w_plane_nxt;
  logic [COL_W-1:0]    r_col, w_col_nxt;
  logic                w_disp_done;
  logic                w_oe_on;

  hub75_bcm_timer #(
    .CNT_W   (CNT_W),
    .PLANE_W (PLANE_W),
    .BASE_ON (BASE_ON)
  ) u_bcm_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (r_state == StLatch),
    .i_plane      (r_plane),
    .i_cnt        (r_cnt),
`ifdef SCAN_BRIGHTNESS_EN
    .i_brightness (i_brightness),
`endif
    .o_done       (w_disp_done),
    .o_oe_on      (w_oe_on)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_row   <= '0;
      r_plane <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_row   <= w_row_nxt;
      r_plane <= w_plane_nxt;
      r_col   <= w_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_plane_nxt = r_plane;
    w_col_nxt   = r_col;
    unique case (r_state)
      StIdle: if (i_en) w_state_nxt = StPre;
      StPre: begin
        if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
          w_state_nxt = StShift;
          w_col_nxt   = '0;
        end
      end
      StShift: begin
        if (r_cnt == CNT_W'(COLS - 1)) w_state_nxt = StPost;
        else                           w_col_nxt   = r_col + 1'b1;
      end
      StPost:    if (r_cnt == CNT_W'(POST_LEN - 1))  w_state_nxt = StLatch;
      StLatch:   if (r_cnt == CNT_W'(LATCH_LEN - 1)) w_state_nxt = StDisplay;
      StDisplay: if (w_disp_done)                    w_state_nxt = StBlank;
      StBlank: begin
        // Row/plane advance only here, so the row never moves while lit.
        if (r_cnt == CNT_W'(DEAD - 1)) begin
          w_state_nxt = i_en ? StPre : StIdle;
          if (r_plane == PLANE_W'(PLANES - 1)) begin
            w_plane_nxt = '0;
            w_row_nxt   = r_row + 1'b1;
          end else begin
            w_plane_nxt = r_plane + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_ce          = (r_state == StPre) || (r_state == StShift);
  assign o_clk_en      = (r_state == StShift) || (r_state == StPost);
  assign o_lat         = (r_state == StLatch);
  assign o_oe          = !((r_state == StDisplay) && w_oe_on);
  assign o_busy        = (r_state == StPre) || (r_state == StShift) || (r_state == StPost);
  assign o_row_addr    = r_row;
  assign o_plane       = r_plane;
  assign o_col_addr    = r_col;
  assign o_frame_start = (r_state == StPre) && (r_row == '0) && (r_plane == '0);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl (COLS=4, ROW_BITS=2, PLANES=2, BASE_ON=8, DEAD=2).
module tb_hub75_scan_ctrl;

  localparam int unsigned COLS     = 4;
  localparam int unsigned ROW_BITS = 2;
  localparam int unsigned PLANES   = 2;
  localparam int unsigned BASE_ON  = 8;
  localparam int unsigned DEAD     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] br  = 8'd255;

  logic       ce, clk_en, lat, oe, busy, frame_start;
  logic [1:0] row_addr;
  logic [0:0] plane;
  logic [1:0] col_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(
    .COLS     (COLS),
    .ROW_BITS (ROW_BITS),
    .PLANES   (PLANES),
    .BASE_ON  (BASE_ON),
    .DEAD     (DEAD)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
`ifdef SCAN_BRIGHTNESS_EN
    .i_brightness  (br),
`endif
    .o_ce          (ce),
    .o_clk_en      (clk_en),
    .o_lat         (lat),
    .o_oe          (oe),
    .o_busy        (busy),
    .o_row_addr    (row_addr),
    .o_plane       (plane),
    .o_col_addr    (col_addr),
    .o_frame_start (frame_start)
  );

  // Row-stability and frame-marker monitor.
  int   cyc = 0;
  int   fs_times[$];
  int   rowviol = 0;
  bit   mon_en = 1'b0;
  logic [1:0] prev_row = '0;
  logic       prev_oe = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (frame_start === 1'b1) fs_times.push_back(cyc);
    if (mon_en && (row_addr !== prev_row) && (!oe || !prev_oe)) rowviol++;
    prev_row = row_addr;
    prev_oe  = oe;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_oe(input int p);
`ifdef SCAN_BRIGHTNESS_EN
    return ((BASE_ON << p) * int'(br)) >> 8;
`else
    return BASE_ON << p;
`endif
  endfunction

  function automatic int exp_len(input int p);
    return 1 + COLS + 1 + 1 + (BASE_ON << p) + DEAD;
  endfunction

  // Starts on a PRE sample; ends on the next PRE sample (or after 400 cycles).
  task automatic measure_plane(output int len, output int nce, output int ncke,
                               output int nlat, output int noel, output int colerr);
    bit seen_low = 1'b0;
    bit done = 1'b0;
    int sidx = 0;
    len = 0; nce = 0; ncke = 0; nlat = 0; noel = 0; colerr = 0;
    while (!done && len < 400) begin
      len++;
      if (ce) nce++;
      if (clk_en) ncke++;
      if (lat) begin
        nlat++;
        if (col_addr != 2'(COLS - 1)) colerr++;
      end
      if (!oe) noel++;
      if (ce && clk_en) begin
        if (int'(col_addr) != sidx) colerr++;
        sidx++;
      end
      if (!ce) seen_low = 1'b1;
      @(negedge clk);
      if (ce && seen_low) done = 1'b1;
    end
  endtask

  initial begin
    int len, nce, ncke, nlat, noel, colerr, bad, p, r, found;

    // Reset, then 10 idle cycles with en low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ce || clk_en || lat || !oe || busy || row_addr != 0 || plane != 0 ||
          col_addr != 0 || frame_start) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_oe", int'(oe), 1);
    chk("idle_busy", int'(busy), 0);

    // Enable: PRE one cycle later with the frame marker.
    en = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("pre_ce", int'(ce), 1);
    chk("pre_busy", int'(busy), 1);
    chk("pre_frame_start", int'(frame_start), 1);

    // Two full frames: 16 planes.
    for (int k = 0; k < 16; k++) begin
      p = k % 2;
      r = (k / 2) % 4;
      chk($sformatf("row_k%0d", k), int'(row_addr), r);
      chk($sformatf("plane_k%0d", k), int'(plane), p);
      measure_plane(len, nce, ncke, nlat, noel, colerr);
      chk($sformatf("len_k%0d", k), len, exp_len(p));
      chk($sformatf("oe_low_k%0d", k), noel, exp_oe(p));
      if (k < 2) begin
        chk($sformatf("ce_k%0d", k), nce, 5);
        chk($sformatf("clk_en_k%0d", k), ncke, 5);
        chk($sformatf("lat_k%0d", k), nlat, 1);
        chk($sformatf("col_k%0d", k), colerr, 0);
      end
    end
    chk("frame2_start", int'(frame_start), 1);

    // Advance to row 1 plane 1 (three planes), then drop en during SHIFT.
    for (int k = 0; k < 3; k++) measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("drop_row", int'(row_addr), 1);
    chk("drop_plane", int'(plane), 1);
    @(negedge clk);
    chk("drop_in_shift", int'(ce && clk_en), 1);
    en = 1'b0;
    nce = 0;
    noel = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ce) nce++;
      if (!oe) noel++;
    end
    chk("drop_ce_rest", nce, 3);
    chk("drop_oe_low", noel, exp_oe(1));
    chk("idle_row", int'(row_addr), 2);
    chk("idle_plane", int'(plane), 0);
    chk("idle2_oe", int'(oe), 1);
    chk("idle2_busy", int'(busy), 0);

    // Resume from row 2 plane 0.
    en = 1'b1;
    @(negedge clk);
    chk("resume_ce", int'(ce), 1);
    chk("resume_row", int'(row_addr), 2);
    chk("resume_plane", int'(plane), 0);
    chk("resume_fs", int'(frame_start), 0);
    measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("resume_len", len, exp_len(0));

    chk("fs_count", int'(fs_times.size() >= 3), 1);
    chk("fs_interval0", (fs_times.size() >= 3) ? fs_times[1] - fs_times[0] : 0, 168);
    chk("fs_interval1", (fs_times.size() >= 3) ? fs_times[2] - fs_times[1] : 0, 168);
    chk("row_change_while_lit", rowviol, 0);
    mon_en = 1'b0;

    // Reset during DISPLAY.
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (!oe) found = 1;
    end
    chk("display_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_oe", int'(oe), 1);
    chk("rst_row", int'(row_addr), 0);
    chk("rst_plane", int'(plane), 0);
    chk("rst_ce", int'(ce), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_col", int'(col_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pre", int'(ce), 1);
    chk("post_rst_fs", int'(frame_start), 1);

`ifdef SCAN_BRIGHTNESS_EN
    br = 8'd128;
    measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("br128_p0_oe", noel, 4);
    measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("br128_p1_oe", noel, 8);
    chk("br128_p1_len", len, 25);
    br = 8'd0;
    measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("br0_p0_oe", noel, 0);
    measure_plane(len, nce, ncke, nlat, noel, colerr);
    chk("br0_p1_oe", noel, 0);
    chk("br0_p1_len", len, 25);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
